ysyx_22050598_mem_arbiter: RTL and testbench

Two-requester memory access controller between the instruction fetch unit (IFU) and the load/store unit (LSU) and one shared single-outstanding memory port. It arbitrates round-robin, captures the winning request, drives it downstream with a valid/ready handshake, waits for the response, and returns read data or a write acknowledge to the owner. Byte length encoding matches the LSU: 1, 2, 4 or 8 bytes in an 8-bit length field.

---
 rtl/ysyx_22050598_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_ysyx_22050598_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_mem_arbiter.sv
// Round-robin arbiter between IFU and LSU onto one single-outstanding memory port.
// Captures the winning request, drives it downstream, and routes the response back to its owner.
module ysyx_22050598_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  // load/store
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_len,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  // downstream memory
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_len,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        len;
  } mem_req_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t   state, state_nxt;
  mem_req_t req_q, grant_req;
  logic     owner, last_owner;
  logic     ifu_win, lsu_win, grant;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  always_comb begin
    ifu_win = ifu_req_valid & (~lsu_req_valid | (last_owner == OWN_LSU));
    lsu_win = lsu_req_valid & (~ifu_req_valid | (last_owner == OWN_IFU));
  end

  // Reset in the same cycle as a grant suppresses the handshake entirely.
  assign ifu_req_ready = (state == IDLE) & ~rst & ifu_win;
  assign lsu_req_ready = (state == IDLE) & ~rst & lsu_win;
  assign grant         = ifu_req_ready | lsu_req_ready;

  always_comb begin
    grant_req = '0;
    if (lsu_win) begin
      grant_req.addr  = lsu_addr;
      grant_req.wen   = lsu_wen;
      grant_req.wdata = lsu_wdata;
      grant_req.len   = lsu_len;
    end else begin
      grant_req.addr  = ifu_addr;
      grant_req.wen   = 1'b0;
      grant_req.wdata = '0;
      grant_req.len   = 8'd8;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)          state_nxt = REQ;
      REQ:     if (mem_req_ready)  state_nxt = RESP;
      RESP:    if (mem_resp_valid) state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_req_valid = (state == REQ);
  end

  assign mem_addr  = req_q.addr;
  assign mem_wen   = req_q.wen;
  assign mem_wdata = req_q.wdata;
  assign mem_len   = req_q.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q          <= '0;
      owner          <= OWN_IFU;
      last_owner     <= OWN_IFU;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      if (grant) begin
        req_q      <= grant_req;
        owner      <= lsu_win;
        last_owner <= lsu_win;
      end
      // Responses outside RESP are stray and dropped.
      if (state == RESP && mem_resp_valid) begin
        if (owner == OWN_LSU) begin
          lsu_rdata      <= mem_rdata;
          lsu_resp_valid <= 1'b1;
        end else begin
          ifu_rdata      <= mem_rdata;
          ifu_resp_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: stimulus pushes expected
// downstream requests and responses; negedge monitors pop and compare.
module tb_ysyx_22050598_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_len;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_len;

  ysyx_22050598_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_len(lsu_len),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  len;
  } mreq_t;

  typedef struct {
    logic        own;   // 0 = IFU, 1 = LSU
    logic [63:0] data;
    logic        chk_data;
    int          lat;
  } resp_t;

  mreq_t   mq[$];
  resp_t   rq[$];
  mreq_t   m;
  resp_t   e;
  int      tests = 0;
  int      fails = 0;
  longint  cyc = 0;
  longint  acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Monitor: responses, accept timestamps and downstream requests.
  always @(negedge clk) begin
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (ifu_resp_valid && lsu_resp_valid) flag("dual_resp");
      else if (rq.size() == 0) flag("unexpected_resp");
      else begin
        e = rq.pop_front();
        chk("resp_owner", 64'(lsu_resp_valid), 64'(e.own));
        if (e.chk_data) chk("resp_data", lsu_resp_valid ? lsu_rdata : ifu_rdata, e.data);
        chk("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
      end
    end
    if ((ifu_req_valid && ifu_req_ready) || (lsu_req_valid && lsu_req_ready)) acc_cyc = cyc;
    if (mem_req_valid === 1'b1) begin
      if (mq.size() == 0) flag("unexpected_mem_req");
      else begin
        m = mq[0];
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_wen", 64'(mem_wen), 64'(m.wen));
        chk("mem_wdata", mem_wdata, m.wdata);
        chk("mem_len", 64'(mem_len), 64'(m.len));
        if (mem_req_ready) void'(mq.pop_front());
      end
    end
  end

  task automatic wait_accept(input string nm, input bit lsu);
    int n = 0;
    @(negedge clk);
    while (!(lsu ? lsu_req_ready : ifu_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) flag(nm);
    @(posedge clk); #1;
  endtask

  // Downstream responder: rdly cycles before ready, vdly cycles before response.
  task automatic serve(input int rdly, input int vdly, input logic [63:0] d);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      flag("serve_timeout");
      return;
    end
    repeat (rdly) begin
      @(negedge clk);
      chk("busy_ready", {62'b0, ifu_req_ready, lsu_req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    repeat (vdly) begin
      @(negedge clk);
      chk("busy_ready", {62'b0, ifu_req_ready, lsu_req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    mem_rdata      = d;
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
    chk({nm, "_mem_addr"}, mem_addr, 64'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({nm, "_mem_wen_len"}, {55'd0, mem_wen, mem_len}, 64'd0);
    chk({nm, "_ifu_rdata"}, ifu_rdata, 64'd0);
    chk({nm, "_lsu_rdata"}, lsu_rdata, 64'd0);
    chk({nm, "_resp_valid"}, {62'd0, ifu_resp_valid, lsu_resp_valid}, 64'd0);
    chk({nm, "_req_ready"}, {62'd0, ifu_req_ready, lsu_req_ready}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 64'h8000_0100; lsu_wen = 1'b0;
    lsu_wdata = 64'h5555; lsu_len = 8'd2;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'h0;

    // Reset with both requesters valid: no handshake, all outputs at reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Tie after reset: LSU, IFU, LSU, IFU.
    mq.push_back('{64'h8000_0100, 1'b0, 64'h5555, 8'd2});
    mq.push_back('{64'h8000_0000, 1'b0, 64'h0, 8'd8});
    mq.push_back('{64'h8000_0100, 1'b0, 64'h5555, 8'd2});
    mq.push_back('{64'h8000_0000, 1'b0, 64'h0, 8'd8});
    rq.push_back('{1'b1, 64'h1111, 1'b1, 3});
    rq.push_back('{1'b0, 64'h0000_0013_0000_0093, 1'b1, 3});
    rq.push_back('{1'b1, 64'h2222, 1'b1, 3});
    rq.push_back('{1'b0, 64'h3333, 1'b1, 3});
    @(posedge clk); #1;
    rst = 1'b0;
    serve(0, 0, 64'h1111);
    serve(0, 0, 64'h0000_0013_0000_0093);
    serve(0, 0, 64'h2222);
    lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    serve(0, 0, 64'h3333);

    // Single load, minimum latency.
    mq.push_back('{64'h8000_0010, 1'b0, 64'h0, 8'd4});
    rq.push_back('{1'b1, 64'h0000_0000_DEAD_BEEF, 1'b1, 3});
    lsu_addr = 64'h8000_0010; lsu_len = 8'd4; lsu_wen = 1'b0; lsu_wdata = 64'h0;
    lsu_req_valid = 1'b1;
    wait_accept("load_accept", 1'b1);
    lsu_req_valid = 1'b0;
    serve(0, 0, 64'h0000_0000_DEAD_BEEF);

    // Stray response in IDLE: nothing happens, data holds.
    repeat (2) @(posedge clk); #1;
    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("idle_stray_req_valid", 64'(mem_req_valid), 64'd0);
    chk("lsu_rdata_hold", lsu_rdata, 64'h0000_0000_DEAD_BEEF);
    chk("ifu_rdata_hold", ifu_rdata, 64'h3333);
    @(posedge clk); #1;

    // Byte store.
    mq.push_back('{64'h8000_1003, 1'b1, 64'hABAB_ABAB_ABAB_ABAB, 8'd1});
    rq.push_back('{1'b1, 64'h0, 1'b0, 3});
    lsu_addr = 64'h8000_1003; lsu_len = 8'd1; lsu_wen = 1'b1; lsu_wdata = 64'hABAB_ABAB_ABAB_ABAB;
    lsu_req_valid = 1'b1;
    wait_accept("store_accept", 1'b1);
    lsu_req_valid = 1'b0;
    serve(0, 0, 64'h0);

    // Downstream stalls with a second fetch pending.
    mq.push_back('{64'h8000_2000, 1'b0, 64'h0, 8'd8});
    mq.push_back('{64'h8000_2008, 1'b0, 64'h0, 8'd8});
    rq.push_back('{1'b0, 64'hCAFE_F00D_1234_5678, 1'b1, 12});
    rq.push_back('{1'b0, 64'h0BAD_C0DE, 1'b1, 3});
    ifu_addr = 64'h8000_2000; ifu_req_valid = 1'b1;
    wait_accept("stall_accept", 1'b0);
    ifu_addr = 64'h8000_2008;
    serve(5, 4, 64'hCAFE_F00D_1234_5678);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    serve(0, 0, 64'h0BAD_C0DE);

    // Stray response in REQ: stays in REQ.
    mq.push_back('{64'h8000_0200, 1'b0, 64'h0, 8'd8});
    rq.push_back('{1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 4});
    lsu_addr = 64'h8000_0200; lsu_len = 8'd8; lsu_wen = 1'b0; lsu_wdata = 64'h0;
    lsu_req_valid = 1'b1;
    wait_accept("req_stray_accept", 1'b1);
    lsu_req_valid = 1'b0;
    mem_rdata = 64'hBAD; mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("req_stray_still_req", 64'(mem_req_valid), 64'd1);
    serve(0, 0, 64'h0123_4567_89AB_CDEF);

    // Reset during RESP, then a late response.
    mq.push_back('{64'h8000_0300, 1'b0, 64'h0, 8'd8});
    lsu_addr = 64'h8000_0300;
    lsu_req_valid = 1'b1;
    wait_accept("rst_accept", 1'b1);
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    mem_rdata = 64'hFEED; mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Tie after reset goes to LSU again even though LSU was granted last.
    mq.push_back('{64'h8000_0400, 1'b0, 64'h77, 8'd4});
    mq.push_back('{64'h8000_0008, 1'b0, 64'h0, 8'd8});
    rq.push_back('{1'b1, 64'h4444, 1'b1, 3});
    rq.push_back('{1'b0, 64'h5555_6666, 1'b1, 3});
    lsu_addr = 64'h8000_0400; lsu_len = 8'd4; lsu_wdata = 64'h77;
    ifu_addr = 64'h8000_0008;
    lsu_req_valid = 1'b1; ifu_req_valid = 1'b1;
    serve(0, 0, 64'h4444);
    lsu_req_valid = 1'b0;
    @(posedge clk); #1;
    ifu_req_valid = 1'b0;
    serve(0, 0, 64'h5555_6666);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mem_queue_drained", 64'(mq.size()), 64'd0);
    chk("resp_queue_drained", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
